// File: rtl/imm_control_sequencer.sv
// rtl/imm_control_sequencer.sv - hardwired fetch/execute control unit for immediate-class instructions
module imm_control_sequencer #(
  parameter int                  ALU_OP_W = 5,
  parameter logic [ALU_OP_W-1:0] ALU_ADD  = 5'b00001,
  parameter logic [ALU_OP_W-1:0] ALU_AND  = 5'b00010,
  parameter logic [ALU_OP_W-1:0] ALU_OR   = 5'b00011,
  parameter logic [4:0]          OP_LOADI = 5'b01000,
  parameter logic [4:0]          OP_ADDI  = 5'b01001,
  parameter logic [4:0]          OP_ANDI  = 5'b01010,
  parameter logic [4:0]          OP_ORI   = 5'b01011,
  parameter logic [4:0]          OP_HALT  = 5'b11011,
  parameter int                  MAX_WAIT = 15,
  parameter int                  CNT_W    = 16
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                run,
  input  logic                step_mode,
  input  logic                mem_ready,
  input  logic [31:0]         IR_Data,
  output logic                PC_enable,
  output logic                PC_increment_enable,
  output logic                IR_enable,
  output logic                Y_enable,
  output logic                Z_enable,
  output logic                MAR_enable,
  output logic                MDR_enable,
  output logic                r_enable,
  output logic                read,
  output logic                Gra,
  output logic                Grb,
  output logic                ba_select,
  output logic                PC_select,
  output logic                Z_LO_select,
  output logic                MDR_select,
  output logic                c_select,
  output logic [ALU_OP_W-1:0] alu_instruction,
  output logic [3:0]          state_out,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    instr_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_HALT = 4'd7
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [4:0] opcode;
  logic       is_loadi, is_addi, is_andi, is_ori, is_halt, is_imm;
  logic       unused_ir;

  assign opcode    = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];
  assign is_loadi  = (opcode == OP_LOADI);
  assign is_addi   = (opcode == OP_ADDI);
  assign is_andi   = (opcode == OP_ANDI);
  assign is_ori    = (opcode == OP_ORI);
  assign is_halt   = (opcode == OP_HALT);
  assign is_imm    = is_loadi | is_addi | is_andi | is_ori;

  assign PC_enable   = 1'b0;
  assign state_out   = state_q;
  assign fault       = fault_q;
  assign instr_count = count_q;

  always_comb begin
    state_d             = state_q;
    wait_d              = wait_q;
    fault_d             = fault_q;
    count_d             = count_q;
    PC_increment_enable = 1'b0;
    IR_enable           = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    MAR_enable          = 1'b0;
    MDR_enable          = 1'b0;
    r_enable            = 1'b0;
    read                = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    ba_select           = 1'b0;
    PC_select           = 1'b0;
    Z_LO_select         = 1'b0;
    MDR_select          = 1'b0;
    c_select            = 1'b0;
    alu_instruction     = '0;
    halted              = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: begin
        PC_select  = 1'b1;
        MAR_enable = 1'b1;
        wait_d     = '0;
        state_d    = S_T1;
      end
      S_T1: begin
        read       = 1'b1;
        MDR_enable = 1'b1;
        // wait_q is zero only on the first T1 cycle, so PC advances once per fetch
        PC_increment_enable = (wait_q == '0);
        if (mem_ready) begin
          state_d = S_T2;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        end
      end
      S_T2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
        state_d    = S_T3;
      end
      S_T3: begin
        if (is_imm) begin
          Grb       = 1'b1;
          Y_enable  = 1'b1;
          ba_select = is_loadi;
          state_d   = S_T4;
        end else begin
          state_d = S_HALT;
          if (!is_halt) fault_d = 1'b1;
        end
      end
      S_T4: begin
        c_select = 1'b1;
        Z_enable = 1'b1;
        if (is_andi)     alu_instruction = ALU_AND;
        else if (is_ori) alu_instruction = ALU_OR;
        else             alu_instruction = ALU_ADD;
        state_d = S_T5;
      end
      S_T5: begin
        Z_LO_select = 1'b1;
        Gra         = 1'b1;
        r_enable    = 1'b1;
        count_d     = count_q + CNT_W'(1);
        state_d     = step_mode ? S_IDLE : S_T0;
      end
      S_HALT: begin
        halted = 1'b1;
        if (run) state_d = S_T0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_imm_control_sequencer.sv
// tb/tb_imm_control_sequencer.sv - scoreboard bench for imm_control_sequencer
module tb_imm_control_sequencer;

  localparam logic [3:0] IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3,
                         T3 = 4'd4, T4 = 4'd5, T5 = 4'd6, HALT = 4'd7;

  localparam logic [15:0] C_PCINC = 16'h4000, C_IREN = 16'h2000, C_YEN = 16'h1000,
                          C_ZEN = 16'h0800, C_MAREN = 16'h0400, C_MDREN = 16'h0200,
                          C_REN = 16'h0100, C_RD = 16'h0080, C_GRA = 16'h0040,
                          C_GRB = 16'h0020, C_BA = 16'h0010, C_PCSEL = 16'h0008,
                          C_ZLO = 16'h0004, C_MDRSEL = 16'h0002, C_CSEL = 16'h0001;
  localparam logic [15:0] F_T0 = C_PCSEL | C_MAREN;
  localparam logic [15:0] F_T1 = C_RD | C_MDREN;
  localparam logic [15:0] F_T2 = C_MDRSEL | C_IREN;
  localparam logic [15:0] F_T3 = C_GRB | C_YEN;
  localparam logic [15:0] F_T4 = C_CSEL | C_ZEN;
  localparam logic [15:0] F_T5 = C_ZLO | C_GRA | C_REN;

  localparam logic [4:0] A_ADD = 5'b00001, A_AND = 5'b00010, A_OR = 5'b00011;

  localparam logic [31:0] IR_LOADI = 32'h4080000A;
  localparam logic [31:0] IR_ADDI  = 32'h48000005;
  localparam logic [31:0] IR_ANDI  = 32'h50000003;
  localparam logic [31:0] IR_ORI   = 32'h58000007;
  localparam logic [31:0] IR_HALT  = 32'hD8000000;
  localparam logic [31:0] IR_BAD   = 32'hF8000000;

  logic clk = 1'b0;
  logic clear, run, step_mode, mem_ready;
  logic [31:0] IR_Data;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable;
  logic MDR_enable, r_enable, read, Gra, Grb, ba_select, PC_select, Z_LO_select;
  logic MDR_select, c_select, halted, fault;
  logic [4:0]  alu_instruction;
  logic [3:0]  state_out;
  logic [15:0] instr_count;
  logic [15:0] ctrl;

  imm_control_sequencer dut (
    .clk(clk), .clear(clear), .run(run), .step_mode(step_mode),
    .mem_ready(mem_ready), .IR_Data(IR_Data),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .r_enable(r_enable),
    .read(read), .Gra(Gra), .Grb(Grb), .ba_select(ba_select),
    .PC_select(PC_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
    .c_select(c_select), .alu_instruction(alu_instruction), .state_out(state_out),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  assign ctrl = {PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
                 MAR_enable, MDR_enable, r_enable, read, Gra, Grb, ba_select,
                 PC_select, Z_LO_select, MDR_select, c_select};

  always #5 clk = ~clk;

  typedef struct {
    logic        clr, run, stp, mr;
    logic [31:0] ir;
    logic [3:0]  st;
    logic [15:0] c;
    logic [4:0]  a;
    logic        h, f;
    logic [15:0] n;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   idx;

  function void p(input logic clr, input logic rn, input logic stp, input logic mr,
                  input logic [31:0] ir, input logic [3:0] st, input logic [15:0] c,
                  input logic [4:0] a, input logic h, input logic f, input logic [15:0] n);
    exp_t x;
    x.clr = clr; x.run = rn; x.stp = stp; x.mr = mr; x.ir = ir;
    x.st = st; x.c = c; x.a = a; x.h = h; x.f = f; x.n = n;
    sb.push_back(x);
  endfunction

  // One full instruction from T0 through T5 with memory immediately ready.
  function void push_instr(input logic [31:0] ir, input logic stp, input logic [4:0] a,
                           input logic ba, input logic [15:0] n);
    p(0, 1, stp, 1, ir, T0, F_T0, 0, 0, 0, n);
    p(0, 1, stp, 1, ir, T1, F_T1 | C_PCINC, 0, 0, 0, n);
    p(0, 1, stp, 1, ir, T2, F_T2, 0, 0, 0, n);
    p(0, 1, stp, 1, ir, T3, F_T3 | (ba ? C_BA : 16'h0), 0, 0, 0, n);
    p(0, 1, stp, 1, ir, T4, F_T4, a, 0, 0, n);
    p(0, 1, stp, 1, ir, T5, F_T5, 0, 0, 0, n);
  endfunction

  task automatic start_clear();
    clear = 1'b1; run = 1'b0; step_mode = 1'b0; mem_ready = 1'b0; IR_Data = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; run = 1'b1; step_mode = 1'b0; mem_ready = 1'b1; IR_Data = IR_LOADI;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state_out !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d exp %0d", state_out, IDLE);
    end
    checks++;
    if (ctrl !== 16'h0 || alu_instruction !== 5'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got ctrl=%h alu=%b h=%b exp 0", ctrl, alu_instruction, halted);
    end
    checks++;
    if (fault !== 1'b0 || instr_count !== 16'h0) begin
      errors++; $display("FAIL reset_regs got f=%b cnt=%0d exp 0/0", fault, instr_count);
    end
  endtask

  task automatic test_loadi();
    start_clear();
    p(0, 1, 0, 1, IR_LOADI, IDLE, 0, 0, 0, 0, 0);
    push_instr(IR_LOADI, 0, A_ADD, 1, 0);
    p(1, 1, 0, 1, IR_LOADI, T0, F_T0, 0, 0, 0, 1);
    p(0, 0, 0, 0, IR_LOADI, IDLE, 0, 0, 0, 0, 0);
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clear = e.clr; run = e.run; step_mode = e.stp; mem_ready = e.mr; IR_Data = e.ir;
      #1;
      checks++;
      if ({state_out, ctrl, alu_instruction, halted, fault, instr_count} !== {e.st, e.c, e.a, e.h, e.f, e.n}) begin
        errors++;
        $display("FAIL loadi[%0d] got st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d exp st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d",
                 idx, state_out, ctrl, alu_instruction, halted, fault, instr_count, e.st, e.c, e.a, e.h, e.f, e.n);
      end
      idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    start_clear();
    p(0, 1, 0, 0, IR_ADDI, IDLE, 0, 0, 0, 0, 0);
    p(0, 1, 0, 0, IR_ADDI, T0, F_T0, 0, 0, 0, 0);
    p(0, 1, 0, 0, IR_ADDI, T1, F_T1 | C_PCINC, 0, 0, 0, 0);
    p(0, 1, 0, 0, IR_ADDI, T1, F_T1, 0, 0, 0, 0);
    p(0, 1, 0, 0, IR_ADDI, T1, F_T1, 0, 0, 0, 0);
    p(0, 1, 0, 1, IR_ADDI, T1, F_T1, 0, 0, 0, 0);
    p(0, 1, 0, 1, IR_ADDI, T2, F_T2, 0, 0, 0, 0);
    p(0, 1, 0, 1, IR_ADDI, T3, F_T3, 0, 0, 0, 0);
    p(0, 1, 0, 1, IR_ADDI, T4, F_T4, A_ADD, 0, 0, 0);
    p(0, 1, 0, 1, IR_ADDI, T5, F_T5, 0, 0, 0, 0);
    p(1, 1, 0, 1, IR_ADDI, T0, F_T0, 0, 0, 0, 1);
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clear = e.clr; run = e.run; step_mode = e.stp; mem_ready = e.mr; IR_Data = e.ir;
      #1;
      checks++;
      if ({state_out, ctrl, alu_instruction, halted, fault, instr_count} !== {e.st, e.c, e.a, e.h, e.f, e.n}) begin
        errors++;
        $display("FAIL mem_wait[%0d] got st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d exp st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d",
                 idx, state_out, ctrl, alu_instruction, halted, fault, instr_count, e.st, e.c, e.a, e.h, e.f, e.n);
      end
      idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    start_clear();
    p(0, 1, 0, 0, IR_ADDI, IDLE, 0, 0, 0, 0, 0);
    p(0, 1, 0, 0, IR_ADDI, T0, F_T0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++)
      p(0, 0, 0, 0, IR_ADDI, T1, F_T1 | (i == 0 ? C_PCINC : 16'h0), 0, 0, 0, 0);
    p(0, 0, 0, 0, IR_ADDI, HALT, 0, 0, 1, 1, 0);
    p(0, 1, 0, 0, IR_ADDI, HALT, 0, 0, 1, 1, 0);
    p(1, 0, 0, 0, IR_ADDI, T0, F_T0, 0, 0, 1, 0);
    p(0, 0, 0, 0, IR_ADDI, IDLE, 0, 0, 0, 0, 0);
    // mem_ready on the last allowed wait cycle still completes the fetch
    p(0, 1, 0, 0, IR_ADDI, IDLE, 0, 0, 0, 0, 0);
    p(0, 1, 0, 0, IR_ADDI, T0, F_T0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++)
      p(0, 1, 0, (i == 14), IR_ADDI, T1, F_T1 | (i == 0 ? C_PCINC : 16'h0), 0, 0, 0, 0);
    p(0, 1, 0, 1, IR_ADDI, T2, F_T2, 0, 0, 0, 0);
    p(1, 1, 0, 1, IR_ADDI, T3, F_T3, 0, 0, 0, 0);
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clear = e.clr; run = e.run; step_mode = e.stp; mem_ready = e.mr; IR_Data = e.ir;
      #1;
      checks++;
      if ({state_out, ctrl, alu_instruction, halted, fault, instr_count} !== {e.st, e.c, e.a, e.h, e.f, e.n}) begin
        errors++;
        $display("FAIL timeout[%0d] got st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d exp st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d",
                 idx, state_out, ctrl, alu_instruction, halted, fault, instr_count, e.st, e.c, e.a, e.h, e.f, e.n);
      end
      idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_illegal();
    start_clear();
    p(0, 1, 0, 1, IR_BAD, IDLE, 0, 0, 0, 0, 0);
    p(0, 1, 0, 1, IR_BAD, T0, F_T0, 0, 0, 0, 0);
    p(0, 1, 0, 1, IR_BAD, T1, F_T1 | C_PCINC, 0, 0, 0, 0);
    p(0, 1, 0, 1, IR_BAD, T2, F_T2, 0, 0, 0, 0);
    p(0, 0, 0, 1, IR_BAD, T3, 0, 0, 0, 0, 0);
    p(0, 0, 0, 1, IR_BAD, HALT, 0, 0, 1, 1, 0);
    p(1, 0, 0, 1, IR_BAD, HALT, 0, 0, 1, 1, 0);
    p(0, 1, 1, 1, IR_ANDI, IDLE, 0, 0, 0, 0, 0);
    push_instr(IR_ANDI, 1, A_AND, 0, 0);
    p(0, 1, 0, 1, IR_HALT, IDLE, 0, 0, 0, 0, 1);
    p(0, 1, 0, 1, IR_HALT, T0, F_T0, 0, 0, 0, 1);
    p(0, 1, 0, 1, IR_HALT, T1, F_T1 | C_PCINC, 0, 0, 0, 1);
    p(0, 1, 0, 1, IR_HALT, T2, F_T2, 0, 0, 0, 1);
    p(0, 0, 0, 1, IR_HALT, T3, 0, 0, 0, 0, 1);
    p(0, 1, 0, 1, IR_HALT, HALT, 0, 0, 1, 0, 1);
    p(1, 1, 0, 1, IR_HALT, T0, F_T0, 0, 0, 0, 1);
    p(0, 0, 0, 1, IR_HALT, IDLE, 0, 0, 0, 0, 0);
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clear = e.clr; run = e.run; step_mode = e.stp; mem_ready = e.mr; IR_Data = e.ir;
      #1;
      checks++;
      if ({state_out, ctrl, alu_instruction, halted, fault, instr_count} !== {e.st, e.c, e.a, e.h, e.f, e.n}) begin
        errors++;
        $display("FAIL halt_illegal[%0d] got st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d exp st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d",
                 idx, state_out, ctrl, alu_instruction, halted, fault, instr_count, e.st, e.c, e.a, e.h, e.f, e.n);
      end
      idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_step_mode();
    start_clear();
    p(0, 1, 1, 1, IR_ANDI, IDLE, 0, 0, 0, 0, 0);
    push_instr(IR_ANDI, 1, A_AND, 0, 0);
    p(0, 1, 1, 1, IR_ORI, IDLE, 0, 0, 0, 0, 1);
    push_instr(IR_ORI, 1, A_OR, 0, 1);
    p(0, 0, 1, 1, IR_ORI, IDLE, 0, 0, 0, 0, 2);
    p(0, 0, 1, 1, IR_ORI, IDLE, 0, 0, 0, 0, 2);
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clear = e.clr; run = e.run; step_mode = e.stp; mem_ready = e.mr; IR_Data = e.ir;
      #1;
      checks++;
      if ({state_out, ctrl, alu_instruction, halted, fault, instr_count} !== {e.st, e.c, e.a, e.h, e.f, e.n}) begin
        errors++;
        $display("FAIL step_mode[%0d] got st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d exp st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d",
                 idx, state_out, ctrl, alu_instruction, halted, fault, instr_count, e.st, e.c, e.a, e.h, e.f, e.n);
      end
      idx++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    start_clear();
    p(0, 1, 0, 1, IR_ADDI, IDLE, 0, 0, 0, 0, 0);
    push_instr(IR_ADDI, 0, A_ADD, 0, 0);
    p(0, 1, 0, 1, IR_ORI, T0, F_T0, 0, 0, 0, 1);
    p(0, 1, 0, 1, IR_ORI, T1, F_T1 | C_PCINC, 0, 0, 0, 1);
    p(0, 1, 0, 1, IR_ORI, T2, F_T2, 0, 0, 0, 1);
    p(0, 1, 0, 1, IR_ORI, T3, F_T3, 0, 0, 0, 1);
    p(1, 1, 0, 1, IR_ORI, T4, F_T4, A_OR, 0, 0, 1);
    p(0, 0, 0, 1, IR_ORI, IDLE, 0, 0, 0, 0, 0);
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      clear = e.clr; run = e.run; step_mode = e.stp; mem_ready = e.mr; IR_Data = e.ir;
      #1;
      checks++;
      if ({state_out, ctrl, alu_instruction, halted, fault, instr_count} !== {e.st, e.c, e.a, e.h, e.f, e.n}) begin
        errors++;
        $display("FAIL back_to_back[%0d] got st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d exp st=%0d ctrl=%h alu=%b h=%b f=%b cnt=%0d",
                 idx, state_out, ctrl, alu_instruction, halted, fault, instr_count, e.st, e.c, e.a, e.h, e.f, e.n);
      end
      idx++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loadi();
    test_mem_wait();
    test_timeout();
    test_halt_illegal();
    test_step_mode();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_control_sequencer.md
Name: imm_control_sequencer

Overview:
- Hardwired control unit that replaces the hand-driven control-step benches for immediate-class instructions (loadi, addi, andi, ori, halt).
- Runs fetch (T0–T2) and execute (T3–T5), one control step per clock.
- Adds a memory-ready wait handshake with timeout, single-step mode, halt/illegal detection and a retired-instruction counter.
- Drives the datapath enable/select ports directly.

Parameters:
- ALU_OP_W, 5, width of alu_instruction.
- ALU_ADD, 5'b00001, ALU code for add (used by loadi and addi).
- ALU_AND, 5'b00010, ALU code for and.
- ALU_OR, 5'b00011, ALU code for or.
- OP_LOADI, 5'b01000, IR[31:27] opcode for loadi.
- OP_ADDI, 5'b01001, opcode for addi.
- OP_ANDI, 5'b01010, opcode for andi.
- OP_ORI, 5'b01011, opcode for ori.
- OP_HALT, 5'b11011, opcode for halt.
- MAX_WAIT, 15, maximum cycles to wait for mem_ready in T1 before faulting.
- CNT_W, 16, width of instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- run  in  1  level; start/resume from IDLE or HALT.
- step_mode  in  1  1 = return to IDLE after every T5.
- mem_ready  in  1  memory read data valid on MDataIN.
- IR_Data  in  32  instruction register contents.
- PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, r_enable  out  1 each  datapath register enables.
- read  out  1  MDR input mux select (memory side).
- Gra, Grb, ba_select  out  1 each  register select/encode controls.
- PC_select, Z_LO_select, MDR_select, c_select  out  1 each  bus source selects.
- alu_instruction  out  ALU_OP_W  ALU opcode.
- state_out  out  4  current state encoding.
- halted  out  1  in HALT state.
- fault  out  1  sticky; set on illegal opcode or memory timeout.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- States: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, HALT=7.
- Outputs are Moore-decoded from the state register. Every output not listed for a state is 0.
- clear=1 at any clock edge, including mid-instruction:
  - state=IDLE, fault=0, instr_count=0, wait counter=0.
  - All control outputs are 0 in the following cycle.
- IDLE: all outputs 0. run=1 -> T0.
- T0: PC_select, MAR_enable. -> T1 (wait counter cleared).
- T1: read and MDR_enable asserted every cycle in T1.
  - PC_increment_enable is asserted only in the first T1 cycle, so PC advances exactly once per fetch regardless of wait length.
  - mem_ready=1 -> T2.
  - mem_ready=0: wait counter increments. If it reaches MAX_WAIT -> HALT with fault=1; the IR is not loaded.
- T2: MDR_select, IR_enable. -> T3. IR_Data is valid from T3 onward.
- Decode in T3 on IR_Data[31:27]:
  - opcode = OP_HALT -> HALT (fault stays 0), no T3 outputs.
  - opcode not in {LOADI, ADDI, ANDI, ORI, HALT} -> HALT with fault=1.
- T3 (legal immediate op): Grb, Y_enable. ba_select=1 only for loadi. -> T4.
- T4: c_select, Z_enable.
  - alu_instruction = ALU_ADD for loadi/addi, ALU_AND for andi, ALU_OR for ori.
  - -> T5.
- T5: Z_LO_select, Gra, r_enable. instr_count increments (wraps modulo 2^CNT_W).
  - step_mode=1 -> IDLE; else -> T0.
- HALT: halted=1, all other control outputs 0.
  - run=1 -> T0. fault is cleared only by clear.
  - halt instructions are not counted.
- Simultaneous events:
  - clear has priority over everything.
  - In IDLE, run=1 with step_mode=1 executes exactly one instruction.
  - mem_ready=1 on the MAX_WAIT-th cycle is a success (no fault).
- PC_enable is reserved for branch support and stays 0 in all states.

Test Plan:
- clear, run=1, mem_ready=1, IR_Data=0x4080000A (loadi R1,0x0A) -> states 1,2,3,4,5,6 on consecutive clocks, ba_select=1 only in T3, alu_instruction=00001 only in T4, r_enable=1 only in T5, instr_count=1.
- mem_ready held 0 for 3 cycles in T1 -> read/MDR_enable high 4 cycles, PC_increment_enable high exactly 1 cycle, then T2.
- mem_ready never asserted -> HALT after MAX_WAIT=15 wait cycles, fault=1, halted=1, IR_enable never asserted.
- IR_Data opcode 5'b11111 -> HALT, fault=1. Opcode OP_HALT -> HALT, fault=0, instr_count unchanged. Then run=1 -> T0.
- step_mode=1 with andi then ori -> IDLE after each T5, alu_instruction 00010 then 00011, instr_count 1 then 2.
- clear asserted during T4 -> next cycle state_out=0, Z_enable=0, instr_count=0, fault=0.
